// File: rtl/fc_pkg.sv
// Shared types and helpers for the streaming fully-connected layer:
// FSM state encoding, accumulator sizing and signed saturation.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC    = 3'd1,
        SCALE  = 3'd2,
        ARGMAX = 3'd3,
        DONE   = 3'd4
    } fc_state_e;

    // Widest intermediate value the saturate helper accepts.
    localparam int SAT_MAX_W = 128;

    // Full-precision product plus growth for summing num_in products.
    function automatic int acc_width(input int dw, input int num_in);
        return 2 * dw + $clog2(num_in);
    endfunction

    // Clamp a wide signed value into the signed range of an ow-bit word.
    function automatic logic signed [SAT_MAX_W-1:0] saturate(
        input logic signed [SAT_MAX_W-1:0] val,
        input int                          ow
    );
        logic signed [SAT_MAX_W-1:0] one_v;
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        logic signed [SAT_MAX_W-1:0] res_v;
        one_v = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        max_v = (one_v <<< (ow - 1)) - one_v;
        min_v = ~max_v;
        if (val > max_v) begin
            res_v = max_v;
        end else if (val < min_v) begin
            res_v = min_v;
        end else begin
            res_v = val;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/fc_stream_layer_mac_lane.sv
// One output channel of the FC layer: full-precision multiply-accumulate,
// then rescale by FRAC and saturate into an OW-bit registered output.
// Optional build macro FC_RELU_EN clamps negative results to zero.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NUM_IN = 192,
    parameter int FRAC   = 16,
    parameter int OW     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 scale,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    output logic signed [OW-1:0] out_q
);

    localparam int AW = acc_width(DW, NUM_IN);

    logic signed [AW-1:0]        acc_q;
    logic signed [AW-1:0]        acc_d;
    logic signed [2*DW-1:0]      prod_s;
    logic signed [AW-1:0]        shifted_s;
    logic signed [SAT_MAX_W-1:0] sat_s;
    logic signed [OW-1:0]        out_d;

    // Next accumulator and scaled output; clear wins over accumulate.
    always_comb begin
        prod_s    = x * w;
        shifted_s = acc_q >>> FRAC;
        sat_s     = saturate(SAT_MAX_W'(shifted_s), OW);
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + AW'(prod_s);
        end else begin
            acc_d = acc_q;
        end
        if (scale) begin
`ifdef FC_RELU_EN
            if (sat_s[SAT_MAX_W-1]) begin
                out_d = '0;
            end else begin
                out_d = OW'(sat_s);
            end
`else
            out_d = OW'(sat_s);
`endif
        end else begin
            out_d = out_q;
        end
    end

    // Accumulator and output registers, cleared by async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/fc_stream_layer.sv
// Start-triggered, back-pressurable fully-connected layer with C parallel
// MAC lanes, saturating rescale and a sequential lowest-index argmax.
// Optional build macro FC_RELU_EN (in the lanes) clamps negative outputs.
module fc_stream_layer
    import fc_pkg::*;
#(
    parameter int C      = 10,
    parameter int NUM_IN = 192,
    parameter int DW     = 32,
    parameter int FRAC   = 16,
    parameter int OW     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [DW-1:0]  in_data,
    input  logic [C*DW-1:0]       w_data,
    output logic [C*OW-1:0]       out_data,
    output logic [$clog2(C)-1:0]  class_idx,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(C);
    localparam int NW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [NW-1:0] LAST_BEAT = NW'(NUM_IN - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(C - 1);

    fc_state_e            state_q, state_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        scan_q, scan_d;
    logic signed [OW-1:0] max_val_q, max_val_d;
    logic [CW-1:0]        max_idx_q, max_idx_d;
    logic [CW-1:0]        class_idx_q, class_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 in_ready_q, in_ready_d;

    logic                 accept_s;
    logic                 lane_clr_s;
    logic                 lane_scale_s;
    logic                 better_s;
    logic signed [OW-1:0] cand_s;
    logic signed [OW-1:0] lane_out_s [C];

    for (genvar k = 0; k < C; k++) begin : g_lane
        fc_mac_lane #(
            .DW     (DW),
            .NUM_IN (NUM_IN),
            .FRAC   (FRAC),
            .OW     (OW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (lane_clr_s),
            .en    (accept_s),
            .scale (lane_scale_s),
            .x     (in_data),
            .w     (w_data[k*DW +: DW]),
            .out_q (lane_out_s[k])
        );
        assign out_data[k*OW +: OW] = lane_out_s[k];
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;

    // FSM next state, beat counting and the one-channel-per-cycle argmax.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scan_d       = scan_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        class_idx_d  = class_idx_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        accept_s     = in_valid && in_ready_q;
        lane_clr_s   = 1'b0;
        lane_scale_s = (state_q == SCALE);
        cand_s       = lane_out_s[scan_q];
        better_s     = (scan_q == {CW{1'b0}}) || (cand_s > max_val_q);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = ACC;
                    cnt_d       = {NW{1'b0}};
                    out_valid_d = 1'b0;
                    class_idx_d = {CW{1'b1}};
                    lane_clr_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ACC: begin
                if (accept_s) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = SCALE;
                        cnt_d   = {NW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            SCALE: begin
                state_d = ARGMAX;
                scan_d  = {CW{1'b0}};
            end
            ARGMAX: begin
                if (better_s) begin
                    max_val_d = cand_s;
                    max_idx_d = scan_q;
                end else begin
                    max_val_d = max_val_q;
                end
                if (scan_q == LAST_CH) begin
                    state_d     = DONE;
                    class_idx_d = max_idx_d;
                    out_valid_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    scan_d = scan_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d     = (state_d == ACC) || (state_d == SCALE) || (state_d == ARGMAX);
        in_ready_d = (state_d == ACC);
    end

    // All control registers; async reset aborts any inference in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= {NW{1'b0}};
            scan_q      <= {CW{1'b0}};
            max_val_q   <= '0;
            max_idx_q   <= {CW{1'b0}};
            class_idx_q <= {CW{1'b1}};
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scan_q      <= scan_d;
            max_val_q   <= max_val_d;
            max_idx_q   <= max_idx_d;
            class_idx_q <= class_idx_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_fc_stream_layer.sv
// Scoreboard bench for fc_stream_layer with C=3, NUM_IN=4 and directed
// hand-computed vectors; honours FC_RELU_EN for the expected values.
module tb_fc_stream_layer;

    localparam int C      = 3;
    localparam int NUM_IN = 4;
    localparam int DW     = 32;
    localparam int FRAC   = 16;
    localparam int OW     = 32;
    localparam int CW     = $clog2(C);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic [C*DW-1:0]      w_data = '0;
    logic [C*OW-1:0]      out_data;
    logic [CW-1:0]        class_idx;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    typedef struct {
        logic [C*OW-1:0] data;
        logic [CW-1:0]   cls;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fc_stream_layer #(.C(C), .NUM_IN(NUM_IN), .DW(DW), .FRAC(FRAC), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_data    (w_data),
        .out_data  (out_data),
        .class_idx (class_idx),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_out_data", out_data, e.data);
                chk("mon_class_idx", class_idx, e.cls);
                chk("mon_out_valid", out_valid, 1'b1);
            end
        end
    end

    function automatic logic [C*DW-1:0] w3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
        return {c, b, a};
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input logic [DW-1:0] x, input logic [C*DW-1:0] w, input int n,
                              input bit gaps);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 32'sh5EAD_BEEF;
                w_data   = {3{32'h1234_5678}};
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = x;
            w_data   = w;
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_err++;
                $display("FAIL ready_timeout: got in_ready=0 expected 1");
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 32'sh0BAD_F00D;
        w_data   = {3{32'h0F0F_0F0F}};
    endtask

    // Cycle 1 is the cycle right after the edge that accepted the last beat.
    task automatic wait_done(output int k);
        k = 1;
        while (k < 60) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            k++;
        end
    endtask

    task automatic finish_checks(input string tag);
        int lat;
        wait_done(lat);
        chk({tag, "_latency"}, lat, C + 2);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_ov_held"}, out_valid, 1'b1);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic run_inf(input string tag, input logic [DW-1:0] x, input logic [C*DW-1:0] w,
                           input logic [C*OW-1:0] ed, input logic [CW-1:0] ec, input bit gaps);
        exp_t e;
        e.data = ed;
        e.cls  = ec;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = x;
        w_data   = w;
        do_start();
        chk({tag, "_ov_cleared"}, out_valid, 1'b0);
        chk({tag, "_cls_ones"}, class_idx, {CW{1'b1}});
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_ready"}, in_ready, 1'b1);
        send_beats(x, w, NUM_IN, gaps);
        finish_checks(tag);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_class_idx"}, class_idx, {CW{1'b1}});
        chk({tag, "_out_data"}, out_data, {(C*OW){1'b0}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [C*OW-1:0] e_fn, e_sn, e_neg, e_tr;
        logic [CW-1:0]   c_neg;
        exp_t            e;
`ifdef FC_RELU_EN
        e_fn  = {32'h0000_0000, 32'h0008_0000, 32'h0002_0000};
        e_sn  = {3{32'h0000_0000}};
        e_neg = {3{32'h0000_0000}};
        c_neg = 2'd0;
        e_tr  = {32'h0000_0000, 32'h0000_0004, 32'h0000_0000};
`else
        e_fn  = {32'hFFFC_0000, 32'h0008_0000, 32'h0002_0000};
        e_sn  = {3{32'h8000_0000}};
        e_neg = {32'hFFF4_0000, 32'hFFFC_0000, 32'hFFF8_0000};
        c_neg = 2'd1;
        e_tr  = {32'h0000_0000, 32'h0000_0004, 32'hFFFF_FFFF};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("por");
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_inf("func", 32'h0001_0000, w3(32'h0000_8000, 32'h0002_0000, 32'hFFFF_0000),
                e_fn, 2'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_state_ov_held", out_valid, 1'b1);
        chk("done_state_cls_held", class_idx, 2'd1);

        run_inf("sat_pos", 32'h7FFF_FFFF, {3{32'h7FFF_FFFF}}, {3{32'h7FFF_FFFF}}, 2'd0, 1'b0);
        run_inf("sat_neg", 32'h7FFF_FFFF, {3{32'h8000_0000}}, e_sn, 2'd0, 1'b0);

        run_inf("tie", 32'h0001_0000, w3(32'h0003_0000, 32'h0001_0000, 32'h0003_0000),
                {32'h000C_0000, 32'h0004_0000, 32'h000C_0000}, 2'd0, 1'b0);
        run_inf("tie_gap", 32'h0001_0000, w3(32'h0003_0000, 32'h0001_0000, 32'h0003_0000),
                {32'h000C_0000, 32'h0004_0000, 32'h000C_0000}, 2'd0, 1'b1);

        run_inf("trunc", 32'h0000_0001, w3(32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0003),
                e_tr, 2'd1, 1'b0);

        // Start pulsed during ACC must not restart the accumulation.
        e.data = {32'h0008_0000, 32'h0004_0000, 32'h0002_0000};
        e.cls  = 2'd2;
        exp_q.push_back(e);
        do_start();
        send_beats(32'h0001_0000, w3(32'h0000_8000, 32'h0001_0000, 32'h0002_0000), 2, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_start_busy", busy, 1'b1);
        chk("ign_start_ready", in_ready, 1'b1);
        send_beats(32'h0001_0000, w3(32'h0000_8000, 32'h0001_0000, 32'h0002_0000), 2, 1'b0);
        finish_checks("ign_start");

        // Reset asserted in ARGMAX aborts with no done pulse.
        do_start();
        send_beats(32'h0001_0000, {3{32'h0001_0000}}, NUM_IN, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_idle_ov", out_valid, 1'b0);

        run_inf("neg", 32'h0001_0000, w3(32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFD_0000),
                e_neg, c_neg, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
